// File: rtl/ppu_pkg.sv
// Shared PPU fetch definitions: default widths, sequential step, NOP encoding and the fetch-entry payload.
package ppu_pkg;

    localparam int unsigned PPU_ADDR_W  = 9;
    localparam int unsigned PPU_DATA_W  = 32;
    localparam int unsigned PPU_PC_STEP = 4;
    localparam logic [PPU_DATA_W-1:0] PPU_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PPU_ADDR_W-1:0] pc;
        logic [PPU_DATA_W-1:0] instr;
    } ppu_fetch_entry_t;

endpackage

// File: rtl/ppu_fetch_fifo.sv
// Ring buffer between fetch and decode: synchronous write, combinational read of the head entry.
module ppu_fetch_fifo
    import ppu_pkg::*;
#(
    parameter int unsigned W     = PPU_ADDR_W + PPU_DATA_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Flush drops everything still queued; a pop in the same cycle has already been consumed.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ppu_fetch_queue.sv
// PPU IF stage: PC/nPC pair, imem read gating, redirect handling and a decoupling queue to ID.
// Optional: define PPU_FETCH_ALIGN_CHECK_EN to word-align redirect targets and pulse misalign_o.
module ppu_fetch_queue
    import ppu_pkg::*;
#(
    parameter int unsigned ADDR_W   = PPU_ADDR_W,
    parameter int unsigned DATA_W   = PPU_DATA_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = PPU_PC_STEP
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fetch_en_i,
    output logic [ADDR_W-1:0]          imem_addr_o,
    output logic                       imem_rd_o,
    input  logic [DATA_W-1:0]          imem_data_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [DATA_W-1:0]          id_instr_o,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       misalign_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [ADDR_W-1:0] target_c;
    logic              pop_c;
    logic              full_c;
    logic [CNT_W-1:0]  count_c;
    entry_t            wr_entry_c;
    entry_t            head_c;

    assign pop_c       = id_valid_o & id_ready_i;
    assign full_c      = (count_c == CNT_W'(DEPTH));
    assign imem_addr_o = pc_q;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign imem_rd_o   = fetch_en_i & ~redirect_i & (~full_c | pop_c);

    assign wr_entry_c.pc    = pc_q;
    assign wr_entry_c.instr = imem_data_i;

    assign id_valid_o = (count_c != '0);
    assign id_instr_o = head_c.instr;
    assign id_pc_o    = head_c.pc;
    assign count_o    = count_c;

`ifdef PPU_FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign target_c   = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign misalign_d = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign target_c   = redirect_pc_i;
    assign misalign_o = 1'b0;
`endif

    // Redirect overrides sequential advance and loads the PC/nPC pair even with fetch disabled.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (redirect_i) begin
            pc_d  = target_c;
            npc_d = target_c + ADDR_W'(PC_STEP);
        end else if (imem_rd_o) begin
            pc_d  = npc_q;
            npc_d = npc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= ADDR_W'(RESET_PC);
            npc_q <= ADDR_W'(RESET_PC + PC_STEP);
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    ppu_fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (imem_rd_o),
        .pop   (pop_c),
        .flush (redirect_i),
        .wdata (wr_entry_c),
        .rdata (head_c),
        .count (count_c)
    );

endmodule

// File: tb/tb_ppu_fetch_queue.sv
// Directed bench for ppu_fetch_queue: vector table for streaming/backpressure/redirect/wrap plus reset and alignment sequences.
module tb_ppu_fetch_queue;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fetch_en_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rd_o;
    logic [DATA_W-1:0] imem_data_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [DATA_W-1:0] id_instr_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [CNT_W-1:0]  count_o;
    logic              misalign_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: each word encodes its own address.
    function automatic logic [DATA_W-1:0] instr_at(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    assign imem_data_i = instr_at(imem_addr_o);

    ppu_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_en_i    (fetch_en_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_o     (imem_rd_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .count_o       (count_o),
        .misalign_o    (misalign_o)
    );

    typedef struct {
        logic              ready;
        logic              fe;
        logic              redir;
        logic [ADDR_W-1:0] rpc;
        logic              exp_valid;
        logic [ADDR_W-1:0] exp_pc;
        logic [ADDR_W-1:0] exp_addr;
        logic [CNT_W-1:0]  exp_cnt;
        logic              exp_rd;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ready, input logic fe, input logic redir,
                                input logic [ADDR_W-1:0] rpc, input logic v,
                                input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] addr,
                                input logic [CNT_W-1:0] cnt, input logic rd);
        vec_t r;
        r.ready = ready; r.fe = fe; r.redir = redir; r.rpc = rpc;
        r.exp_valid = v; r.exp_pc = pc; r.exp_addr = addr; r.exp_cnt = cnt; r.exp_rd = rd;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic exp_mis;

    initial begin
        // ready fe redir rpc valid head_pc addr cnt rd
        tv.push_back(mk(1, 1, 0, 9'h000, 0, 9'h000, 9'h000, 0, 1)); // streaming
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h000, 9'h004, 1, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h004, 9'h008, 1, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h008, 9'h00C, 1, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h00C, 9'h010, 1, 1));
        tv.push_back(mk(0, 1, 0, 9'h000, 1, 9'h010, 9'h014, 1, 1)); // backpressure
        tv.push_back(mk(0, 1, 0, 9'h000, 1, 9'h010, 9'h018, 2, 1));
        tv.push_back(mk(0, 1, 0, 9'h000, 1, 9'h010, 9'h01C, 3, 1));
        tv.push_back(mk(0, 1, 0, 9'h000, 1, 9'h010, 9'h020, 4, 0));
        tv.push_back(mk(0, 1, 0, 9'h000, 1, 9'h010, 9'h020, 4, 0));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h010, 9'h020, 4, 1)); // full + pop
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h014, 9'h024, 4, 1));
        tv.push_back(mk(1, 1, 1, 9'h040, 1, 9'h018, 9'h028, 4, 0)); // redirect, full, pop
        tv.push_back(mk(1, 1, 0, 9'h000, 0, 9'h000, 9'h040, 0, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h040, 9'h044, 1, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h044, 9'h048, 1, 1));
        tv.push_back(mk(1, 0, 0, 9'h000, 1, 9'h048, 9'h04C, 1, 0)); // fetch disabled, drain
        tv.push_back(mk(1, 0, 0, 9'h000, 0, 9'h000, 9'h04C, 0, 0));
        tv.push_back(mk(1, 1, 1, 9'h1FC, 0, 9'h000, 9'h04C, 0, 0)); // wrap
        tv.push_back(mk(1, 1, 0, 9'h000, 0, 9'h000, 9'h1FC, 0, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h1FC, 9'h000, 1, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h000, 9'h004, 1, 1));
        tv.push_back(mk(1, 0, 1, 9'h080, 1, 9'h004, 9'h008, 1, 0)); // redirect, fetch off
        tv.push_back(mk(1, 0, 0, 9'h000, 0, 9'h000, 9'h080, 0, 0));
        tv.push_back(mk(1, 1, 0, 9'h000, 0, 9'h000, 9'h080, 0, 1));
        tv.push_back(mk(1, 1, 0, 9'h000, 1, 9'h080, 9'h084, 1, 1));

        reset_n       = 1'b0;
        fetch_en_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        id_ready_i    = 1'b0;
        next_cycle();
        next_cycle();

        check("rst_addr",     32'(imem_addr_o), 32'h0);
        check("rst_valid",    32'(id_valid_o),  32'h0);
        check("rst_count",    32'(count_o),     32'h0);
        check("rst_instr",    32'(id_instr_o),  32'h0);
        check("rst_id_pc",    32'(id_pc_o),     32'h0);
        check("rst_misalign", 32'(misalign_o),  32'h0);

        reset_n = 1'b1;
        next_cycle();

        foreach (tv[i]) begin
            id_ready_i    = tv[i].ready;
            fetch_en_i    = tv[i].fe;
            redirect_i    = tv[i].redir;
            redirect_pc_i = tv[i].rpc;
            #1;
            check($sformatf("v%0d_valid", i), 32'(id_valid_o),  32'(tv[i].exp_valid));
            check($sformatf("v%0d_count", i), 32'(count_o),     32'(tv[i].exp_cnt));
            check($sformatf("v%0d_addr", i),  32'(imem_addr_o), 32'(tv[i].exp_addr));
            check($sformatf("v%0d_rd", i),    32'(imem_rd_o),   32'(tv[i].exp_rd));
            check($sformatf("v%0d_mis", i),   32'(misalign_o),  32'h0);
            if (tv[i].exp_valid) begin
                check($sformatf("v%0d_pc", i),    32'(id_pc_o),    32'(tv[i].exp_pc));
                check($sformatf("v%0d_instr", i), id_instr_o,      instr_at(tv[i].exp_pc));
            end
            next_cycle();
        end
        redirect_i = 1'b0;

        // Mid-run asynchronous reset with entries queued.
        id_ready_i = 1'b0;
        fetch_en_i = 1'b1;
        next_cycle();
        next_cycle();
        check("pre_rst_count", 32'(count_o), 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_addr",  32'(imem_addr_o), 32'h0);
        check("arst_valid", 32'(id_valid_o),  32'h0);
        check("arst_count", 32'(count_o),     32'h0);
        next_cycle();
        reset_n    = 1'b1;
        id_ready_i = 1'b1;
        #1;
        check("rel_rd", 32'(imem_rd_o), 32'h1);
        next_cycle();
        check("rel_valid", 32'(id_valid_o), 32'h1);
        check("rel_pc",    32'(id_pc_o),    32'h0);
        check("rel_instr", id_instr_o,      instr_at(9'h000));
        check("rel_count", 32'(count_o),    32'h1);

        // Misaligned redirect target.
        redirect_i    = 1'b1;
        redirect_pc_i = 9'h043;
        next_cycle();
        redirect_i = 1'b0;
`ifdef PPU_FETCH_ALIGN_CHECK_EN
        exp_mis = 1'b1;
        check("al_addr", 32'(imem_addr_o), 32'h40);
`else
        exp_mis = 1'b0;
        check("al_addr", 32'(imem_addr_o), 32'h43);
`endif
        check("al_mis_pulse", 32'(misalign_o), 32'(exp_mis));
        check("al_count",     32'(count_o),    32'h0);
        next_cycle();
        check("al_mis_clear", 32'(misalign_o), 32'h0);
        check("al_valid",     32'(id_valid_o), 32'h1);
`ifdef PPU_FETCH_ALIGN_CHECK_EN
        check("al_head_pc", 32'(id_pc_o), 32'h40);
`else
        check("al_head_pc", 32'(id_pc_o), 32'h43);
`endif
        next_cycle();
        check("al_mis_stay", 32'(misalign_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
